// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// One arbitration cycle per grant, bursts of up to MAX_BURST words, stalls on fifo_full.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam logic [7:0] LastBeat = 8'(MAX_BURST - 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e          r_state;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   r_rr_ptr;
    logic [7:0]      r_burst_cnt;

    logic                  w_found;
    logic [IW-1:0]         w_pick;
    logic [IW-1:0]         w_idx;
    logic [IW-1:0]         w_next_ptr;
    logic                  w_gvalid;
    logic [DATA_WIDTH-1:0] w_gdata;
    logic                  w_xfer;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = IW'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_gvalid = 1'b0;
        w_gdata  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == IW'(i)) begin
                w_gvalid = req_valid[i];
                w_gdata  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        busy   = (r_state == StGrant);
        w_xfer = busy && w_gvalid && !fifo_full;
        wr_en  = w_xfer;
        wr_data = w_xfer ? w_gdata : '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = busy && !fifo_full && (r_grant_id == IW'(i));
        end
        grant_id   = r_grant_id;
        w_next_ptr = (32'(r_grant_id) == NUM_REQ - 1) ? '0 : r_grant_id + 1'b1;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_state     <= StIdle;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_grant_id  <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= StGrant;
                    end
                end
                StGrant: begin
                    // A dropped valid releases even while the FIFO is full.
                    if (!w_gvalid || (w_xfer && r_burst_cnt == LastBeat)) begin
                        r_state  <= StIdle;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: requester word streams feed the DUT and a
// scoreboard of expected (requester, word) writes is checked as wr_en fires.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            wr_clk = 1'b0;
    logic            wr_rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .wr_clk    (wr_clk),
        .wr_rst_n  (wr_rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #10 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DW-1:0] src_mem [N][8];
    int            src_len [N];
    int            src_pos [N];
    logic [N-1:0]  src_en = '0;
    logic          full_next = 1'b0;

    logic          obs_wr_en, obs_busy;
    logic [1:0]    obs_grant;
    logic [N-1:0]  obs_ready;

    // Scoreboard: every write must match the next expected (requester, word).
    always begin
        exp_t e;
        @(negedge wr_clk);
        #1;
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_write: got id %0d data %0h, required no write",
                         grant_id, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (grant_id !== e.id || wr_data !== e.d) begin
                    n_errors++;
                    $display("FAIL sb_write: got id %0d data %0h, required id %0d data %0h",
                             grant_id, wr_data, e.id, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        src_en = '0;
    endtask

    task automatic load(input int r, input int cnt, input logic [DW-1:0] base);
        for (int k = 0; k < cnt; k++) src_mem[r][k] = base + DW'(k);
        src_len[r] = cnt;
        src_pos[r] = 0;
        src_en[r]  = 1'b1;
    endtask

    task automatic expect_words(input int r, input int first, input int cnt,
                                input logic [DW-1:0] base);
        exp_t e;
        for (int k = first; k < first + cnt; k++) begin
            e.id = 2'(r);
            e.d  = base + DW'(k);
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, retire accepted words.
    task automatic step();
        @(negedge wr_clk);
        fifo_full = full_next;
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && src_pos[i] < src_len[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = src_mem[i][src_pos[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
        #1;
        obs_wr_en = wr_en;
        obs_busy  = busy;
        obs_grant = grant_id;
        obs_ready = req_ready;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) src_pos[i]++;
        end
    endtask

    task automatic reset_dut();
        @(negedge wr_clk);
        wr_rst_n  = 1'b0;
        clear_src();
        full_next = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #3;
        wr_rst_n  = 1'b1;
    endtask

    task automatic check_sb_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drained: got %0d pending writes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || grant_id !== 2'd0 ||
            wr_data !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got wr_en %b busy %b ready %b grant %0d data %0h, required all 0",
                     wr_en, busy, req_ready, grant_id, wr_data);
        end
        for (int i = 0; i < N; i++) load(i, 4, DW'(8'h10 * i));
        expect_words(0, 0, 1, 8'h00);
        step();
        step();
        n_checks++;
        if (obs_wr_en !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_preburst: got wr_en %b, required 1", obs_wr_en);
        end
        // Mid-cycle async pulse; the word presented above is never clocked in.
        #1 wr_rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0 || wr_data !== '0) begin
            n_errors++;
            $display("FAIL reset_async: got wr_en %b ready %b busy %b data %0h, required 0",
                     wr_en, req_ready, busy, wr_data);
        end
        #2 wr_rst_n = 1'b1;
        src_pos[0] = 0;
        expect_words(0, 0, 1, 8'h00);
        step();
        n_checks++;
        if (obs_busy !== 1'b1 || obs_grant !== 2'd0 || obs_wr_en !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_first_grant: got busy %b grant %0d wr_en %b, required 1 0 1",
                     obs_busy, obs_grant, obs_wr_en);
        end
        check_sb_empty("reset");
    endtask

    task automatic test_single();
        logic [9:0] en_pat;
        logic [9:0] busy_pat;
        en_pat   = 10'b0011011110;
        busy_pat = 10'b0111011110;
        reset_dut();
        load(1, 6, 8'hA0);
        expect_words(1, 0, 6, 8'hA0);
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (obs_wr_en !== en_pat[k] || obs_busy !== busy_pat[k]) begin
                n_errors++;
                $display("FAIL single_cycle%0d: got wr_en %b busy %b, required %b %b",
                         k, obs_wr_en, obs_busy, en_pat[k], busy_pat[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (obs_grant !== 2'd1) begin
                    n_errors++;
                    $display("FAIL single_grant%0d: got %0d, required 1", k, obs_grant);
                end
            end
        end
        check_sb_empty("single");
    endtask

    task automatic test_contention();
        int writes;
        writes = 0;
        reset_dut();
        load(0, 5, 8'h00);
        for (int i = 1; i < N; i++) load(i, 4, DW'(8'h10 * i));
        for (int i = 0; i < N; i++) expect_words(i, 0, 4, DW'(8'h10 * i));
        expect_words(0, 4, 1, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step();
            if (obs_wr_en === 1'b1) writes++;
            n_checks++;
            if (obs_busy !== ((k % 5) != 0)) begin
                n_errors++;
                $display("FAIL contention_busy%0d: got %b, required %b", k, obs_busy, (k % 5) != 0);
            end
        end
        n_checks++;
        if (writes != 16) begin
            n_errors++;
            $display("FAIL contention_writes: got %0d, required 16", writes);
        end
        for (int k = 0; k < 4; k++) step();
        check_sb_empty("contention");
    endtask

    task automatic test_backpressure();
        logic [11:0] en_pat;
        en_pat = 12'b0010_1100_0110;
        reset_dut();
        load(2, 5, 8'hC0);
        expect_words(2, 0, 5, 8'hC0);
        for (int k = 0; k < 12; k++) begin
            full_next = (k >= 3 && k <= 5);
            step();
            n_checks++;
            if (obs_wr_en !== en_pat[k]) begin
                n_errors++;
                $display("FAIL bp_wr_en%0d: got %b, required %b", k, obs_wr_en, en_pat[k]);
            end
            if (k >= 1 && k <= 7) begin
                n_checks++;
                if (obs_grant !== 2'd2 || obs_busy !== 1'b1 ||
                    obs_ready !== (full_next ? 4'b0000 : 4'b0100)) begin
                    n_errors++;
                    $display("FAIL bp_hold%0d: got grant %0d busy %b ready %b", k, obs_grant,
                             obs_busy, obs_ready);
                end
            end
        end
        full_next = 1'b0;
        check_sb_empty("backpressure");
    endtask

    task automatic test_early_release();
        reset_dut();
        load(0, 1, 8'h50);
        load(1, 4, 8'h60);
        load(3, 4, 8'h70);
        expect_words(0, 0, 1, 8'h50);
        expect_words(1, 0, 4, 8'h60);
        expect_words(3, 0, 4, 8'h70);
        for (int k = 0; k < 15; k++) begin
            step();
            if (k == 2 || k == 3 || k == 8) begin
                n_checks++;
                if (obs_wr_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL early_gap%0d: got wr_en %b, required 0", k, obs_wr_en);
                end
            end
            if (k == 4 || k == 9) begin
                n_checks++;
                if (obs_grant !== ((k == 4) ? 2'd1 : 2'd3)) begin
                    n_errors++;
                    $display("FAIL early_grant%0d: got %0d, required %0d", k, obs_grant,
                             (k == 4) ? 1 : 3);
                end
            end
        end
        check_sb_empty("early");
    endtask

    task automatic test_overflow_guard();
        int bad;
        bad = 0;
        reset_dut();
        full_next = 1'b1;
        for (int i = 0; i < N; i++) load(i, 4, DW'(8'h10 * i));
        step();
        for (int k = 0; k < 50; k++) begin
            step();
            n_checks++;
            if (obs_wr_en !== 1'b0 || obs_busy !== 1'b1 || obs_grant !== 2'd0) begin
                n_errors++;
                $display("FAIL overflow%0d: got wr_en %b busy %b grant %0d, required 0 1 0",
                         k, obs_wr_en, obs_busy, obs_grant);
            end
        end
        full_next = 1'b0;
        check_sb_empty("overflow");
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_overflow_guard();
        reset_dut();
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
